// File: rtl/siso_tx_scheduler.sv
// Two-requester serial frame transmitter: round-robin pick in IDLE, then a
// start bit, N data bits MSB first, and a one-cycle gap with a done pulse.
module siso_tx_scheduler #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         req0,
    input  logic [N-1:0] data0,
    input  logic         req1,
    input  logic [N-1:0] data1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         out,
    output logic         frame,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

    state_t         state_q;
    logic [N-1:0]   shreg_q;
    logic [CW-1:0]  cnt_q;
    logic           last1_q;
    logic           pick0_c;

    // Requester 0 wins alone, or on a tie when requester 1 was served last.
    assign pick0_c = req0 & (~req1 | last1_q);

    // Outputs are registered from the next state, so out always equals the
    // shift-register MSB while a data bit is on the line.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            last1_q <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            out     <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    out   <= 1'b0;
                    frame <= 1'b0;
                    busy  <= 1'b0;
                    if (req0 | req1) begin
                        state_q <= START;
                        shreg_q <= pick0_c ? data0 : data1;
                        last1_q <= ~pick0_c;
                        gnt0    <= pick0_c;
                        gnt1    <= ~pick0_c;
                        out     <= 1'b1;
                        frame   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    out     <= shreg_q[N-1];
                end
                SHIFT: begin
                    shreg_q <= shreg_q << 1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                        out     <= 1'b0;
                        frame   <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        out   <= shreg_q[N-2];
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    out     <= 1'b0;
                    frame   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_tx_scheduler.sv
// Directed bench for siso_tx_scheduler (N=4); each cycle compares the packed
// output vector {gnt1,gnt0,frame,out,busy,done} against hand-derived values.
module tb_siso_tx_scheduler;

    localparam int unsigned N = 4;

    logic         clk;
    logic         clear;
    logic         req0;
    logic [N-1:0] data0;
    logic         req1;
    logic [N-1:0] data1;
    logic         gnt0;
    logic         gnt1;
    logic         out;
    logic         frame;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    siso_tx_scheduler #(.N(N)) dut (
        .clk   (clk),
        .clear (clear),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .out   (out),
        .frame (frame),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] obs();
        return {gnt1, gnt0, frame, out, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (gnt1 gnt0 frame out busy done) at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one frame starting at the acceptance edge; mess disturbs inputs mid-SHIFT.
    task automatic expect_frame(input string tag, input logic g, input logic [N-1:0] d,
                                input logic drop, input logic mess);
        logic [5:0] exp;
        for (int i = 0; i <= int'(N) + 1; i++) begin
            tick();
            if (i == 0)
                exp = {g, ~g, 4'b1110};
            else if (i <= int'(N))
                exp = {2'b00, 1'b1, d[N-i], 2'b10};
            else
                exp = 6'b000011;
            chk($sformatf("%s[%0d]", tag, i), obs(), exp);
            if (i == 0 && drop) begin
                if (g) req1 = 1'b0;
                else   req0 = 1'b0;
            end
            if (i == 2 && mess) begin
                data0 = ~data0;
                req1  = 1'b1;
            end
        end
    endtask

    initial begin
        clear = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = '0;
        data1 = '0;

        // Reset asserted before the first edge.
        #1 clear = 1'b1;
        #1 chk("reset_async", obs(), 6'b000000);
        tick();
        tick();
        chk("reset_held", obs(), 6'b000000);
        clear = 1'b0;

        // Lone requester 0.
        req0  = 1'b1;
        data0 = 4'b1011;
        expect_frame("single", 1'b0, 4'b1011, 1'b1, 1'b0);
        tick();
        chk("single_idle", obs(), 6'b000000);
        tick();
        chk("single_idle2", obs(), 6'b000000);

        // Clear pulsed between edges, then a tie goes to requester 0 first.
        #2 clear = 1'b1;
        #2 clear = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 4'b1011;
        data1 = 4'b0110;
        expect_frame("tie_a", 1'b0, 4'b1011, 1'b1, 1'b0);
        tick();
        chk("tie_gap_idle", obs(), 6'b000000);
        expect_frame("tie_b", 1'b1, 4'b0110, 1'b1, 1'b0);
        tick();
        chk("tie_idle", obs(), 6'b000000);

        // Both held high: grants alternate with a 7-cycle period.
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 4'b1100;
        data1 = 4'b0011;
        for (int f = 0; f < 4; f++) begin
            expect_frame($sformatf("cont%0d", f), f[0], f[0] ? 4'b0011 : 4'b1100, 1'b0, 1'b0);
            if (f == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            chk($sformatf("cont%0d_idle", f), obs(), 6'b000000);
        end

        // Input changes mid-frame leave the current frame alone.
        req0  = 1'b1;
        data0 = 4'b1001;
        data1 = 4'b0101;
        expect_frame("midchg", 1'b0, 4'b1001, 1'b1, 1'b0 | 1'b1);
        tick();
        chk("midchg_idle", obs(), 6'b000000);
        expect_frame("midchg_r1", 1'b1, 4'b0101, 1'b1, 1'b0);
        tick();
        chk("midchg_r1_idle", obs(), 6'b000000);

        // Abort during SHIFT bit 2 with requester 1 pending.
        req0  = 1'b1;
        data0 = 4'b1011;
        tick();
        chk("abort_start", obs(), 6'b011110);
        req0  = 1'b0;
        req1  = 1'b1;
        data1 = 4'b0110;
        tick();
        tick();
        tick();
        chk("abort_bit2", obs(), 6'b001110);
        #2 clear = 1'b1;
        #1 chk("abort_async", obs(), 6'b000000);
        tick();
        chk("abort_nodone", obs(), 6'b000000);
        clear = 1'b0;
        req0  = 1'b1;
        expect_frame("recover_a", 1'b0, 4'b1011, 1'b1, 1'b0);
        tick();
        chk("recover_idle", obs(), 6'b000000);
        expect_frame("recover_b", 1'b1, 4'b0110, 1'b1, 1'b0);
        tick();
        chk("recover_end", obs(), 6'b000000);
        tick();
        chk("recover_quiet", obs(), 6'b000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
